// File: rtl/cla16_pipe_adder.sv
// cla16_pipe_adder: two-stage valid/ready 16-bit carry-lookahead add/subtract with nibble group signals
module cla16_pipe_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf,
    output logic        pb_n,
    output logic        gb_n
);
    logic [15:0] bx, p, g;
    logic        c0;
    logic [3:0]  pb, gb;
    logic        s1_valid, s1_c0, s1_sub;
    logic [15:0] s1_a, s1_bx;
    logic [3:0]  s1_pb, s1_gb;
    logic        s1_load, s2_load;
    logic [15:0] x, q, h, nsum;
    logic [3:0]  np, ng;
    logic [4:0]  nc;
    logic        ci, c, blk_g;

    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;
    assign p  = a | bx;
    assign g  = a & bx;

    for (genvar k = 0; k < 4; k++) begin : g_nib
        assign pb[k] = ~&p[4*k +: 4];
        assign gb[k] = ~(g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1]) | (&p[4*k+1 +: 3] & g[4*k]));
    end

    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_a   <= a;
            s1_bx  <= bx;
            s1_c0  <= c0;
            s1_sub <= sub;
            s1_pb  <= pb;
            s1_gb  <= gb;
        end
    end

    assign np    = ~s1_pb;
    assign ng    = ~s1_gb;
    assign ci    = s1_c0 | s1_sub;
    assign blk_g = ng[3] | (np[3] & ng[2]) | (&np[3:2] & ng[1]) | (&np[3:1] & ng[0]);
    assign nc[0] = ci;
    assign nc[1] = ng[0] | (np[0] & ci);
    assign nc[2] = ng[1] | (np[1] & ng[0]) | (&np[1:0] & ci);
    assign nc[3] = ng[2] | (np[2] & ng[1]) | (&np[2:1] & ng[0]) | (&np[2:0] & ci);
    assign nc[4] = blk_g | (&np & ci);

    assign x = s1_a ^ s1_bx;
    assign q = s1_a | s1_bx;
    assign h = s1_a & s1_bx;

    always_comb begin
        nsum = '0;
        c    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            c = nc[k];
            for (int j = 0; j < 4; j++) begin
                nsum[4*k+j] = x[4*k+j] ^ c;
                c = h[4*k+j] | (q[4*k+j] & c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            pb_n      <= 1'b1;
            gb_n      <= 1'b1;
        end else begin
            s1_valid  <= s1_load | (s1_valid & ~s2_load);
            out_valid <= s2_load | (out_valid & ~out_ready);
            if (s2_load) begin
                sum  <= nsum;
                cout <= nc[4];
                ovf  <= (s1_a[15] == s1_bx[15]) & (nsum[15] != s1_a[15]);
                pb_n <= |s1_pb;
                gb_n <= ~blk_g;
            end
        end
    end
endmodule

// File: tb/tb_cla16_pipe_adder.sv
// tb_cla16_pipe_adder: directed and random stimulus with a queue scoreboard checking cla16_pipe_adder results
module tb_cla16_pipe_adder;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, cin = 1'b0;
    logic        out_ready = 1'b0, ready_cmd = 1'b0, rnd = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, pb_n, gb_n;
    logic [15:0] sum;
    int          tests = 0, fails = 0;
    logic [19:0] sb[$];
    logic [19:0] held = '0;
    logic        held_v = 1'b0;

    cla16_pipe_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .pb_n(pb_n), .gb_n(gb_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] act;
        act = {cout, ovf, pb_n, gb_n, sum};
        if (held_v && out_valid)
            chk("stall_hold", act, held);
        held_v = rst_n && out_valid && !out_ready;
        held = act;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h expected none", act);
            end else
                chk("result", act, sb.pop_front());
        end
    end

    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
        logic [15:0] ex;
        logic [16:0] r, gr;
        ex = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ex} + {16'b0, s | c};
        gr = {1'b0, x} + {1'b0, ex};
        return {r[16], (x[15] == ex[15]) && (r[15] != x[15]), ~&(x | ex), ~gr[16], r[15:0]};
    endfunction

    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vs, input logic vc, input logic [19:0] exp);
        a = va;
        b = vb;
        sub = vs;
        cin = vc;
        in_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready got 0 expected 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb.size() != 0; t++)
            @(posedge clk);
        #1;
        chk("drain_empty", 20'(sb.size()), 20'h0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs, rc;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", {cout, ovf, pb_n, gb_n, sum}, 20'h30000);
        chk("reset_out_valid", 20'(out_valid), 20'h0);
        chk("reset_in_ready", 20'(in_ready), 20'h1);
        rst_n = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 20'h80000);
        in_valid = 1'b0;
        chk("latency_edge1", 20'(out_valid), 20'h0);
        @(posedge clk);
        #1;
        chk("latency_edge2", 20'(out_valid), 20'h1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 20'h78000);
        send(16'h0005, 16'h0007, 1'b1, 1'b0, 20'h3FFFE);
        send(16'h0007, 16'h0005, 1'b1, 1'b0, 20'h80002);
        send(16'h1234, 16'h4321, 1'b0, 1'b1, 20'h35556);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 20'hE0000);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 20'hE7FFF);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 20'h30001);
        send(16'h0003, 16'h0003, 1'b1, 1'b1, 20'h90000);
        in_valid = 1'b0;
        drain();
        ready_cmd = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 20'h30002);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 20'h30100);
        a = 16'hABCD;
        b = 16'h1111;
        sub = 1'b0;
        cin = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 20'(in_ready), 20'h0);
            @(posedge clk);
            #1;
        end
        ready_cmd = 1'b1;
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 20'h3BCDE);
        send(16'hF000, 16'h1000, 1'b0, 1'b0, 20'hA0000);
        in_valid = 1'b0;
        drain();
        ready_cmd = 1'b0;
        send(16'h1111, 16'h1111, 1'b0, 1'b0, 20'h32222);
        send(16'h2222, 16'h2222, 1'b0, 1'b0, 20'h34444);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_outputs", {cout, ovf, pb_n, gb_n, sum}, 20'h30000);
        chk("midrst_out_valid", 20'(out_valid), 20'h0);
        chk("midrst_in_ready", 20'(in_ready), 20'h1);
        ready_cmd = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("midrst_no_stale", 20'(out_valid), 20'h0);
        end
        send(16'h0001, 16'h0002, 1'b0, 1'b1, 20'h30004);
        in_valid = 1'b0;
        drain();
        rnd = 1'b1;
        repeat (10000) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            send(ra, rb, rs, rc, model(ra, rb, rs, rc));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        rnd = 1'b0;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
